multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports as listed:
  i_clk  in  1  single clock, rising edge
  i_rst_n  in  1  asynchronous active-low reset
  i_instrCode  in  12  {opcode[31:26], funct[5:0]} from IR
  i_memReady  in  1  memory access completes this cycle
  i_zero  in  1  ALU zero flag (informational; branch qualification done by datapath via o_pcWriteCond)
  o_pcWrite  out  1  unconditional PC load
  o_pcWriteCond  out  1  PC load if zero
  o_iorD  out  1  0=PC addresses memory, 1=ALUOut
  o_memRead  out  1  memory read strobe
  o_memWrite  out  1  memory write strobe
  o_irWrite  out  1  IR load
  o_memToReg  out  1  0=ALUOut, 1=MDR to register file
  o_regDst  out  1  0=rt, 1=rd
  o_regWrite  out  1  register file write
  o_aluSrcA  out  1  0=PC, 1=A
  o_aluSrcB  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
  o_aluOp  out  2  00=add, 01=sub, 10=funct-decoded
  o_pcSrc  out  2  00=ALU, 01=ALUOut, 10=jump target
  o_state  out  4  current state code
  o_instrDone  out  1  one-cycle pulse when an instruction retires
  o_illegal  out  1  one-cycle pulse on unsupported opcode

Function
REQ-002 SHALL be a Moore FSM; outputs decode from the state register, gated only by i_memReady where stated.
REQ-003 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-004 FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00; irWrite and pcWrite=i_memReady; SHALL hold until i_memReady=1, then go to DECODE.
REQ-005 DECODE: aluSrcA=0, aluSrcB=11, aluOp=00; next state by opcode: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX (per REQ-015); any other opcode->FETCH with o_illegal=1 for that cycle.
REQ-006 MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00; go to MEMRD if opcode=100011, else MEMWR.
REQ-007 MEMRD: memRead=1, iorD=1; SHALL hold until i_memReady=1, then go to MEMWB.
REQ-008 MEMWB: regWrite=1, regDst=0, memToReg=1; go to FETCH.
REQ-009 MEMWR: memWrite=1, iorD=1; SHALL hold until i_memReady=1, then go to FETCH.
REQ-010 EXEC: aluSrcA=1, aluSrcB=00, aluOp=10; go to ALUWB. ALUWB: regWrite=1, regDst=1, memToReg=0; go to FETCH.
REQ-011 BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, pcWriteCond=1; go to FETCH. JUMP: pcWrite=1, pcSrc=10; go to FETCH.
REQ-012 Unlisted outputs in each state SHALL be 0; memWrite and memRead SHALL never be 1 together.
REQ-013 o_instrDone SHALL pulse for exactly one cycle on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB; it SHALL NOT pulse on an illegal opcode.
REQ-014 With i_memReady held 1, cycles per instruction SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-016 While i_rst_n=0, state SHALL be FETCH and o_pcWrite, o_pcWriteCond, o_irWrite, o_memRead, o_memWrite, o_regWrite, o_instrDone and o_illegal SHALL be 0; all other outputs SHALL hold their FETCH values.
REQ-017 Assertion mid-instruction, including during a memory wait, SHALL abort to FETCH immediately; the first fetch SHALL begin on the first rising edge after deassertion.

Configuration
REQ-015 Macro MULTICYCLE_ADDI_EN: when defined, opcode 001000 SHALL go to ADDIEX (aluSrcA=1, aluSrcB=10, aluOp=00) then ADDIWB (regWrite=1, regDst=0, memToReg=0), then FETCH; when undefined, states 9 and 10 SHALL not exist and opcode 001000 SHALL be illegal per REQ-005.

Verification
REQ-018 Reset, then lw (opcode 100011) with i_memReady=1 -> o_state 0,1,2,3,4,0; o_regWrite=1 only in state 4; o_instrDone pulse after 5 cycles.
REQ-019 sw with i_memReady low for 3 cycles in MEMWR -> o_memWrite=1 for 4 cycles; state stays 5 until ready, then 0.
REQ-020 R-type add {000000,100000} -> states 0,1,6,7,0; aluOp=10 in state 6; regDst=1 in state 7.
REQ-021 beq then j -> state 8 with pcWriteCond=1 and pcSrc=01, then state 11 with pcWrite=1 and pcSrc=10; 3 cycles each.
REQ-022 Opcode 111111 -> o_illegal pulses in DECODE, next state 0, no o_instrDone; addi with MULTICYCLE_ADDI_EN undefined -> same result, and with it defined -> states 0,1,9,10,0.
REQ-023 i_rst_n pulsed low during MEMRD wait -> all write enables drop to 0 at once; after release, the FETCH sequence restarts.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS-style datapath
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_instrCode[11:0]  {opcode, funct} from the instruction register
//   i_memReady         memory access completes this cycle
//   i_zero             ALU zero flag (branch qualification is done in the datapath)
//   o_pcWrite .. o_pcSrc  datapath strobes and mux selects
//   o_state            current state code
//   o_instrDone        one-cycle pulse in the FETCH cycle following a retired instruction
//   o_illegal          one-cycle pulse in DECODE for an unsupported opcode
// Build option: define MULTICYCLE_ADDI_EN to add the ADDIEX/ADDIWB path for addi.
module multicycle_control (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] i_instrCode,
    input  logic        i_memReady,
    input  logic        i_zero,
    output logic        o_pcWrite,
    output logic        o_pcWriteCond,
    output logic        o_iorD,
    output logic        o_memRead,
    output logic        o_memWrite,
    output logic        o_irWrite,
    output logic        o_memToReg,
    output logic        o_regDst,
    output logic        o_regWrite,
    output logic        o_aluSrcA,
    output logic [1:0]  o_aluSrcB,
    output logic [1:0]  o_aluOp,
    output logic [1:0]  o_pcSrc,
    output logic [3:0]  o_state,
    output logic        o_instrDone,
    output logic        o_illegal
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
`ifdef MULTICYCLE_ADDI_EN
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
`endif
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    state_t     state, nextState;
    logic       doneReg, retire;
    logic       pcWrite, pcWriteCond, memRead, memWrite, irWrite, regWrite, illegal;
    logic [5:0] opcode;
    logic       unusedInputs;

    assign opcode       = i_instrCode[11:6];
    assign unusedInputs = ^{i_instrCode[5:0], i_zero};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= FETCH;
            doneReg <= 1'b0;
        end else begin
            state   <= nextState;
            doneReg <= retire;
        end
    end

    always_comb begin
        nextState   = FETCH;
        retire      = 1'b0;
        illegal     = 1'b0;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        regWrite    = 1'b0;
        o_iorD      = 1'b0;
        o_memToReg  = 1'b0;
        o_regDst    = 1'b0;
        o_aluSrcA   = 1'b0;
        o_aluSrcB   = 2'b00;
        o_aluOp     = 2'b00;
        o_pcSrc     = 2'b00;
        case (state)
            FETCH: begin
                memRead   = 1'b1;
                irWrite   = i_memReady;
                pcWrite   = i_memReady;
                o_aluSrcB = 2'b01;
                nextState = i_memReady ? DECODE : FETCH;
            end
            DECODE: begin
                o_aluSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_R:         nextState = EXEC;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      nextState = ADDIEX;
`endif
                    default:      illegal   = 1'b1;
                endcase
            end
            MEMADR: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
                nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memRead   = 1'b1;
                o_iorD    = 1'b1;
                nextState = i_memReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regWrite   = 1'b1;
                o_memToReg = 1'b1;
                retire     = 1'b1;
            end
            MEMWR: begin
                memWrite  = 1'b1;
                o_iorD    = 1'b1;
                retire    = i_memReady;
                nextState = i_memReady ? FETCH : MEMWR;
            end
            EXEC: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = 2'b10;
                nextState = ALUWB;
            end
            ALUWB: begin
                regWrite = 1'b1;
                o_regDst = 1'b1;
                retire   = 1'b1;
            end
            BRANCH: begin
                o_aluSrcA   = 1'b1;
                o_aluOp     = 2'b01;
                o_pcSrc     = 2'b01;
                pcWriteCond = 1'b1;
                retire      = 1'b1;
            end
`ifdef MULTICYCLE_ADDI_EN
            ADDIEX: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = 2'b10;
                nextState = ADDIWB;
            end
            ADDIWB: begin
                regWrite = 1'b1;
                retire   = 1'b1;
            end
`endif
            JUMP: begin
                pcWrite = 1'b1;
                o_pcSrc = 2'b10;
                retire  = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked by reset directly so they drop the moment reset asserts,
    // even though FETCH itself would request a memory read.
    assign o_pcWrite     = pcWrite & i_rst_n;
    assign o_pcWriteCond = pcWriteCond & i_rst_n;
    assign o_memRead     = memRead & i_rst_n;
    assign o_memWrite    = memWrite & i_rst_n;
    assign o_irWrite     = irWrite & i_rst_n;
    assign o_regWrite    = regWrite & i_rst_n;
    assign o_illegal     = illegal & i_rst_n;
    assign o_instrDone   = doneReg;
    assign o_state       = state;
endmodule
